// File: rtl/noc_pkg.sv
// Shared types for the mesh edge network interface: default-geometry flit
// layout, RX state encoding and the statistics counter width.
package noc_pkg;

  localparam int unsigned STAT_W      = 16;
  localparam int unsigned NOC_DATA_W  = 32;
  localparam int unsigned NOC_COORD_W = 4;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_HOLD = 1'b1
  } rx_state_e;

  // Flit layout at the default geometry; modules build the same field order at their own widths.
  typedef struct packed {
    logic [NOC_COORD_W-1:0] dest_y;
    logic [NOC_COORD_W-1:0] dest_x;
    logic [NOC_DATA_W-1:0]  data;
  } flit_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                 input logic              inc);
    return (inc && (v != '1)) ? v + STAT_W'(1) : v;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Circular flit FIFO with wrap-bit pointers, registered flags and a registered head.
module flit_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i & ready_q;
  assign pop_ok  = pop_i & valid_q;

  // Flags and head are computed from the post-update pointers so they are valid the cycle after.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    valid_d  = (wr_ptr_d != rd_ptr_d);
    ready_d  = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    head_d   = '0;
    if (valid_d) begin
      // A write into the slot that becomes the head is not yet visible in mem_q.
      if (push_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
        head_d = wdata_i;
      end else begin
        head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign head_o  = head_q;

endmodule

// File: rtl/edge_ni.sv
// Mesh edge network interface: host TX FIFO towards the mesh, address-filtered RX hold
// register towards the host. Statistics counters are built only with EDGE_NI_STATS_EN.
module edge_ni
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COORD_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned LOCAL_X     = 0,
  parameter int unsigned LOCAL_Y     = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                host_tx_valid,
  output logic                                host_tx_ready,
  input  logic [COORD_WIDTH-1:0]              host_tx_dest_x,
  input  logic [COORD_WIDTH-1:0]              host_tx_dest_y,
  input  logic [DATA_WIDTH-1:0]               host_tx_data,
  output logic                                mesh_out_valid,
  input  logic                                mesh_out_ready,
  output logic [DATA_WIDTH+2*COORD_WIDTH-1:0] mesh_out_flit,
  input  logic                                mesh_in_valid,
  output logic                                mesh_in_ready,
  input  logic [DATA_WIDTH+2*COORD_WIDTH-1:0] mesh_in_flit,
  output logic                                host_rx_valid,
  input  logic                                host_rx_ready,
  output logic [DATA_WIDTH-1:0]               host_rx_data,
  output logic [STAT_W-1:0]                   stat_tx_cnt,
  output logic [STAT_W-1:0]                   stat_rx_cnt,
  output logic [STAT_W-1:0]                   stat_drop_cnt
);

  localparam int unsigned FLIT_W = DATA_WIDTH + 2 * COORD_WIDTH;

  typedef struct packed {
    logic [COORD_WIDTH-1:0] dest_y;
    logic [COORD_WIDTH-1:0] dest_x;
    logic [DATA_WIDTH-1:0]  data;
  } ni_flit_t;

  ni_flit_t tx_flit;
  ni_flit_t in_flit;

  assign tx_flit = '{dest_y: host_tx_dest_y, dest_x: host_tx_dest_x, data: host_tx_data};
  assign in_flit = mesh_in_flit;

  flit_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (host_tx_valid),
    .wdata_i (tx_flit),
    .pop_i   (mesh_out_ready),
    .ready_o (host_tx_ready),
    .valid_o (mesh_out_valid),
    .head_o  (mesh_out_flit)
  );

  rx_state_e             state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  in_accept;
  logic                  in_match;

  assign in_accept = mesh_in_valid & in_ready_q;
  assign in_match  = (in_flit.dest_x == COORD_WIDTH'(LOCAL_X)) &&
                     (in_flit.dest_y == COORD_WIDTH'(LOCAL_Y));

  // RX next state; ready/valid are registered decodes of the next state.
  always_comb begin
    state_d   = state_q;
    rx_data_d = rx_data_q;
    unique case (state_q)
      RX_IDLE: begin
        if (in_accept && in_match) begin
          rx_data_d = in_flit.data;
          state_d   = RX_HOLD;
        end
      end
      RX_HOLD: begin
        if (host_rx_ready) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
    in_ready_d = (state_d == RX_IDLE);
    rx_valid_d = (state_d == RX_HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RX_IDLE;
      in_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign mesh_in_ready = in_ready_q;
  assign host_rx_valid = rx_valid_q;
  assign host_rx_data  = rx_data_q;

`ifdef EDGE_NI_STATS_EN
  logic [STAT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [STAT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [STAT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating event counters.
  always_comb begin
    tx_cnt_d   = sat_inc(tx_cnt_q, mesh_out_valid & mesh_out_ready);
    rx_cnt_d   = sat_inc(rx_cnt_q, in_accept & in_match);
    drop_cnt_d = sat_inc(drop_cnt_q, in_accept & ~in_match);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign stat_tx_cnt   = tx_cnt_q;
  assign stat_rx_cnt   = rx_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`else
  assign stat_tx_cnt   = '0;
  assign stat_rx_cnt   = '0;
  assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_edge_ni.sv
// Self-checking bench for edge_ni: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with sporadic resets.
module tb_edge_ni;

  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 4;
  localparam int unsigned FW    = DW + 2 * CW;
  localparam int unsigned DEPTH = 4;
`ifdef EDGE_NI_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          host_tx_valid;
  logic          host_tx_ready;
  logic [CW-1:0] host_tx_dest_x;
  logic [CW-1:0] host_tx_dest_y;
  logic [DW-1:0] host_tx_data;
  logic          mesh_out_valid;
  logic          mesh_out_ready;
  logic [FW-1:0] mesh_out_flit;
  logic          mesh_in_valid;
  logic          mesh_in_ready;
  logic [FW-1:0] mesh_in_flit;
  logic          host_rx_valid;
  logic          host_rx_ready;
  logic [DW-1:0] host_rx_data;
  logic [15:0]   stat_tx_cnt;
  logic [15:0]   stat_rx_cnt;
  logic [15:0]   stat_drop_cnt;

  edge_ni #(
    .DATA_WIDTH  (DW),
    .COORD_WIDTH (CW),
    .FIFO_DEPTH  (DEPTH),
    .LOCAL_X     (0),
    .LOCAL_Y     (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .host_tx_valid  (host_tx_valid),
    .host_tx_ready  (host_tx_ready),
    .host_tx_dest_x (host_tx_dest_x),
    .host_tx_dest_y (host_tx_dest_y),
    .host_tx_data   (host_tx_data),
    .mesh_out_valid (mesh_out_valid),
    .mesh_out_ready (mesh_out_ready),
    .mesh_out_flit  (mesh_out_flit),
    .mesh_in_valid  (mesh_in_valid),
    .mesh_in_ready  (mesh_in_ready),
    .mesh_in_flit   (mesh_in_flit),
    .host_rx_valid  (host_rx_valid),
    .host_rx_ready  (host_rx_ready),
    .host_rx_data   (host_rx_data),
    .stat_tx_cnt    (stat_tx_cnt),
    .stat_rx_cnt    (stat_rx_cnt),
    .stat_drop_cnt  (stat_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue for TX, a hold flag for RX, integer counters.
  logic [FW-1:0] tx_q[$];
  bit            m_live;
  bit            m_hold;
  logic [DW-1:0] m_rx_data;
  int            m_tx, m_rx, m_drop;

  function automatic int sat16(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_q.delete();
      m_live    = 1'b0;
      m_hold    = 1'b0;
      m_rx_data = '0;
      m_tx      = 0;
      m_rx      = 0;
      m_drop    = 0;
    end else begin
      bit push, pop, acc;
      push = host_tx_valid && m_live && (tx_q.size() < DEPTH);
      pop  = mesh_out_ready && (tx_q.size() != 0);
      acc  = mesh_in_valid && m_live && !m_hold;
      if (pop) begin
        void'(tx_q.pop_front());
        m_tx = sat16(m_tx);
      end
      if (push) tx_q.push_back({host_tx_dest_y, host_tx_dest_x, host_tx_data});
      if (m_hold) begin
        if (host_rx_ready) m_hold = 1'b0;
      end else if (acc) begin
        if (mesh_in_flit[FW-1:DW] == '0) begin
          m_hold    = 1'b1;
          m_rx_data = mesh_in_flit[DW-1:0];
          m_rx      = sat16(m_rx);
        end else begin
          m_drop = sat16(m_drop);
        end
      end
      m_live = 1'b1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [FW-1:0] ef;
    ef = (tx_q.size() != 0) ? tx_q[0] : '0;
    chk("host_tx_ready", 64'(host_tx_ready), 64'(m_live && (tx_q.size() < DEPTH)));
    chk("mesh_out_valid", 64'(mesh_out_valid), 64'(tx_q.size() != 0));
    chk("mesh_out_flit", 64'(mesh_out_flit), 64'(ef));
    chk("mesh_in_ready", 64'(mesh_in_ready), 64'(m_live && !m_hold));
    chk("host_rx_valid", 64'(host_rx_valid), 64'(m_hold));
    chk("host_rx_data", 64'(host_rx_data), 64'(m_rx_data));
    chk("stat_tx_cnt", 64'(stat_tx_cnt), STATS ? 64'(m_tx) : 64'd0);
    chk("stat_rx_cnt", 64'(stat_rx_cnt), STATS ? 64'(m_rx) : 64'd0);
    chk("stat_drop_cnt", 64'(stat_drop_cnt), STATS ? 64'(m_drop) : 64'd0);
  end

  task automatic idle_inputs();
    host_tx_valid  = 1'b0;
    host_tx_dest_x = '0;
    host_tx_dest_y = '0;
    host_tx_data   = '0;
    mesh_out_ready = 1'b0;
    mesh_in_valid  = 1'b0;
    mesh_in_flit   = '0;
    host_rx_ready  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_tx_ready", 64'(host_tx_ready), 64'd0);
    chk("reset_in_ready", 64'(mesh_in_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("first_cycle_tx_ready", 64'(host_tx_ready), 64'd1);
    chk("first_cycle_in_ready", 64'(mesh_in_ready), 64'd1);

    // Single packet to (0,0).
    do_reset();
    host_tx_valid  = 1'b1;
    host_tx_data   = 32'hDEADBEEF;
    mesh_out_ready = 1'b1;
    @(negedge clk);
    host_tx_valid = 1'b0;
    #1;
    chk("single_valid", 64'(mesh_out_valid), 64'd1);
    chk("single_flit", 64'(mesh_out_flit), 64'h00_DEADBEEF);
    @(negedge clk);
    #1;
    chk("single_tx_cnt", 64'(stat_tx_cnt), STATS ? 64'd1 : 64'd0);
    chk("single_drained", 64'(mesh_out_valid), 64'd0);

    // Fill to full with the mesh stalled, then drain in order.
    do_reset();
    host_tx_valid  = 1'b1;
    host_tx_dest_x = 4'd1;
    host_tx_dest_y = 4'd1;
    for (int i = 0; i < 5; i++) begin
      host_tx_data = 32'(100 + i);
      @(negedge clk);
      #1;
      if (i == 3) chk("full_after_4", 64'(host_tx_ready), 64'd0);
    end
    host_tx_valid  = 1'b0;
    mesh_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 64'(mesh_out_flit[DW-1:0]), 64'(100 + i));
      @(negedge clk);
      #1;
    end
    chk("drain_empty", 64'(mesh_out_valid), 64'd0);

    // Ten push/pop pairs through the wrap point.
    do_reset();
    host_tx_valid  = 1'b1;
    mesh_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      host_tx_data = 32'(200 + i);
      @(negedge clk);
      #1;
      chk("wrap_data", 64'(mesh_out_flit[DW-1:0]), 64'(200 + i));
      chk("wrap_not_full", 64'(host_tx_ready), 64'd1);
      chk("wrap_not_empty", 64'(mesh_out_valid), 64'd1);
    end
    host_tx_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("wrap_final_empty", 64'(mesh_out_valid), 64'd0);

    // Non-matching destination (1,2) is dropped.
    do_reset();
    mesh_in_valid = 1'b1;
    mesh_in_flit  = {4'd2, 4'd1, 32'h12345678};
    @(negedge clk);
    mesh_in_valid = 1'b0;
    #1;
    chk("drop_no_valid", 64'(host_rx_valid), 64'd0);
    chk("drop_cnt", 64'(stat_drop_cnt), STATS ? 64'd1 : 64'd0);
    chk("drop_in_ready", 64'(mesh_in_ready), 64'd1);

    // Matching flit held while the host stalls.
    do_reset();
    mesh_in_valid = 1'b1;
    mesh_in_flit  = {4'd0, 4'd0, 32'hCAFEF00D};
    @(negedge clk);
    mesh_in_flit = {4'd0, 4'd0, 32'h11111111};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_in_ready", 64'(mesh_in_ready), 64'd0);
      chk("hold_valid", 64'(host_rx_valid), 64'd1);
      chk("hold_data", 64'(host_rx_data), 64'hCAFEF00D);
      @(negedge clk);
    end
    host_rx_ready = 1'b1;
    mesh_in_valid = 1'b0;
    @(negedge clk);
    host_rx_ready = 1'b0;
    #1;
    chk("release_in_ready", 64'(mesh_in_ready), 64'd1);
    chk("release_valid", 64'(host_rx_valid), 64'd0);

    // Asynchronous reset with two flits queued and one held.
    do_reset();
    host_tx_valid = 1'b1;
    host_tx_data  = 32'hA5A5A5A5;
    mesh_in_valid = 1'b1;
    mesh_in_flit  = {4'd0, 4'd0, 32'h5A5A5A5A};
    repeat (2) @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 64'(mesh_out_valid), 64'd0);
    chk("arst_flit", 64'(mesh_out_flit), 64'd0);
    chk("arst_tx_ready", 64'(host_tx_ready), 64'd0);
    chk("arst_rx_valid", 64'(host_rx_valid), 64'd0);
    chk("arst_rx_data", 64'(host_rx_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("arst_after_empty", 64'(mesh_out_valid), 64'd0);
    chk("arst_after_ready", 64'(host_tx_ready), 64'd1);

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      host_tx_valid  = ($urandom_range(0, 99) < 60);
      host_tx_dest_x = CW'($urandom_range(0, 1));
      host_tx_dest_y = CW'($urandom_range(0, 1));
      host_tx_data   = $urandom;
      mesh_out_ready = ($urandom_range(0, 99) < 55);
      mesh_in_valid  = ($urandom_range(0, 99) < 50);
      mesh_in_flit   = {CW'($urandom_range(0, 1)), CW'($urandom_range(0, 1)), DW'($urandom)};
      host_rx_ready  = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 499) == 0) begin
        #3;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
